// File: rtl/exec_alu_if.sv
// -----------------------------------------------------------------------------
// exec_alu_if -- operation/result bundle for the exec_alu execution unit.
//
// Signals (direction as seen by the ALU, i.e. the slave modport):
//   in_valid    in   op/src/dst/flag_we present this cycle
//   in_ready    out  ALU can accept an op this cycle
//   op          in   4-bit operation select
//   src, dst    in   WIDTH-bit operands
//   flag_we     in   op updates the CCR when it completes
//   flush       in   abort any in-flight multiply, block acceptance
//   ccr_restore in   reload CCR from ccr_in (interrupt return)
//   ccr_in      in   CCR reload value {C,V,N,Z}
//   out_valid   out  result valid for this one cycle
//   result      out  WIDTH-bit result, held while out_valid is low
//   ccr         out  condition codes {C,V,N,Z}
//   busy        out  multiply in progress
// -----------------------------------------------------------------------------
interface exec_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dst;
  logic             flag_we;
  logic             flush;
  logic             ccr_restore;
  logic [3:0]       ccr_in;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       ccr;
  logic             busy;

  // Issuing side (pipeline / testbench).
  modport master (
    output in_valid, op, src, dst, flag_we, flush, ccr_restore, ccr_in,
    input  in_ready, out_valid, result, ccr, busy
  );

  // ALU side.
  modport slave (
    input  in_valid, op, src, dst, flag_we, flush, ccr_restore, ccr_in,
    output in_ready, out_valid, result, ccr, busy
  );
endinterface

// File: rtl/exec_alu.sv
// -----------------------------------------------------------------------------
// exec_alu -- execution-stage ALU with condition codes and an iterative
// shift-add multiplier.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  exec_alu_if.slave (handshake, operands, result, CCR, busy)
//
// Parameters:
//   WIDTH   operand/result width, 8..32
//   MUL_EN  1 = MUL runs the iterative multiplier, 0 = MUL acts as PASS
//
// Single-cycle ops register their result and flags on the accepting edge and
// raise out_valid for the following cycle, so they can issue back to back.
// MUL spends WIDTH cycles in S_MUL (one shift-add step each) and one cycle in
// S_DONE presenting the product; in_ready is low and busy high throughout.
// -----------------------------------------------------------------------------
module exec_alu #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input logic        clk,
  input logic        rst,
  exec_alu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_NOT  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  // Condition codes are packed {C,V,N,Z}.
  function automatic logic [3:0] pack_ccr(input logic c, input logic v,
                                          input logic [WIDTH-1:0] r);
    return {c, v, r[WIDTH-1], (r == '0)};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic             flag_pend_q, flag_pend_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       ccr_q,       ccr_d;
  logic             in_ready_q,  in_ready_d;
  logic             busy_q,      busy_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  op_e              op;
  logic             accept;
  logic [4:0]       sh_amt;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_bx;
  logic             add_sub;
  logic             add_use;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] acc_step;
  logic             mul_last;

  assign op     = op_e'(bus.op);
  assign accept = bus.in_valid & in_ready_q & ~bus.flush;
  assign sh_amt = bus.src[4:0];

  // One spare bit catches the last bit shifted out; amounts >= WIDTH shift
  // the whole operand away, leaving a zero result.
  assign shl_ext = {1'b0, bus.dst} << sh_amt;
  assign shr_ext = {bus.dst, 1'b0} >> sh_amt;

  // NOTE: every value written in always_comb gets a default first, otherwise a
  // path that skips the assignment would infer a latch.
  always_comb begin
    add_a   = bus.dst;
    add_b   = bus.src;
    add_sub = 1'b0;
    add_use = 1'b0;
    alu_res = bus.dst;
    alu_c   = 1'b0;
    alu_v   = 1'b0;

    case (op)
      OP_ADD: add_use = 1'b1;
      OP_SUB: begin
        add_use = 1'b1;
        add_sub = 1'b1;
      end
      OP_INC: begin
        add_a   = bus.src;
        add_b   = WIDTH'(1);
        add_use = 1'b1;
      end
      OP_DEC: begin
        add_a   = bus.src;
        add_b   = WIDTH'(1);
        add_use = 1'b1;
        add_sub = 1'b1;
      end
      OP_NOT: alu_res = ~bus.src;
      OP_AND: alu_res = bus.dst & bus.src;
      OP_OR:  alu_res = bus.dst | bus.src;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      default: alu_res = bus.dst;  // PASS, reserved codes, MUL when disabled
    endcase

    // Subtract as a + ~b + 1; the carry out is then the inverse of the borrow.
    add_bx  = add_sub ? ~add_b : add_b;
    add_sum = {1'b0, add_a} + {1'b0, add_bx} + {{WIDTH{1'b0}}, add_sub};

    if (add_use) begin
      alu_res = add_sum[WIDTH-1:0];
      alu_c   = add_sum[WIDTH] ^ add_sub;
      alu_v   = (add_a[WIDTH-1] == add_bx[WIDTH-1]) &&
                (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    end
  end

  // One shift-add step: only the low WIDTH product bits are kept, so the
  // multiplicand can simply shift left inside a WIDTH-bit register.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_last = (cnt_q == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    flag_pend_d = flag_pend_q;
    result_d    = result_q;
    out_valid_d = 1'b0;          // out_valid is a one-cycle pulse
    ccr_d       = ccr_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    if (bus.flush) begin
      // Abort anything in flight; result and CCR keep their old values.
      state_d    = S_IDLE;
      cnt_d      = '0;
      in_ready_d = 1'b1;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (MUL_EN && (op == OP_MUL)) begin
              state_d     = S_MUL;
              cnt_d       = '0;
              mcand_d     = bus.dst;
              mplier_d    = bus.src;
              acc_d       = '0;
              flag_pend_d = bus.flag_we;
              in_ready_d  = 1'b0;
              busy_d      = 1'b1;
            end else begin
              result_d    = alu_res;
              out_valid_d = 1'b1;
              if (bus.flag_we) ccr_d = pack_ccr(alu_c, alu_v, alu_res);
            end
          end
        end

        S_MUL: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (mul_last) begin
            state_d     = S_DONE;
            result_d    = acc_step;
            out_valid_d = 1'b1;
            if (flag_pend_q) ccr_d = pack_ccr(1'b0, 1'b0, acc_step);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_DONE: begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end

        default: begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
      endcase
    end

    // An interrupt-return reload wins over any flag update on the same edge.
    if (bus.ccr_restore) ccr_d = bus.ccr_in;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      flag_pend_q <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ccr_q       <= 4'b0000;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      flag_pend_q <= flag_pend_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ccr_q       <= ccr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ccr       = ccr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_exec_alu.sv
// -----------------------------------------------------------------------------
// tb_exec_alu -- scoreboard bench for exec_alu (WIDTH=16, MUL_EN=1).
// Stimulus pushes the hand-computed {result, ccr} of each op that should
// complete; an independent monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_exec_alu;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_INC  = 4'd8;
  localparam logic [3:0] OP_DEC  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  ccr;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  exec_alu_if #(.WIDTH(16)) bus ();

  exec_alu #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present one op for one cycle; optionally register its expected response.
  task automatic send(input logic [3:0] o, input logic [15:0] d, input logic [15:0] s,
                      input logic fw, input bit expect_out,
                      input logic [15:0] eres, input logic [3:0] eccr, input string nm);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.dst      = d;
    bus.src      = s;
    bus.flag_we  = fw;
    if (expect_out) exp_q.push_back('{res: eres, ccr: eccr, name: nm});
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.flush       = 1'b0;
    bus.ccr_restore = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_result"}, {16'd0, bus.result}, {16'd0, e.res});
          check({e.name, "_ccr"}, {28'd0, bus.ccr}, {28'd0, e.ccr});
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cyc;
    int ov_cyc;

    rst             = 1'b0;
    bus.in_valid    = 1'b0;
    bus.op          = OP_PASS;
    bus.src         = '0;
    bus.dst         = '0;
    bus.flag_we     = 1'b0;
    bus.flush       = 1'b0;
    bus.ccr_restore = 1'b0;
    bus.ccr_in      = 4'b0000;

    // ---- reset state --------------------------------------------------------
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    {16'd0, bus.result},    32'd0);
    check("rst_ccr",       {28'd0, bus.ccr},       32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // ---- single-cycle ops ---------------------------------------------------
    send(OP_ADD, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b0110, "add_ovf");
    idle();
    @(negedge clk);

    // Back-to-back; the NOT leaves the CCR as the SUB set it.
    send(OP_SUB, 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 4'b0001, "sub_zero");
    send(OP_NOT, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 4'b0001, "not_nofl");
    send(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 1'b1, 16'h3030, 4'b0000, "and");
    send(OP_OR,  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8001, 4'b0010, "or_neg");
    send(OP_SHR, 16'h8001, 16'h0001, 1'b1, 1'b1, 16'h4000, 4'b1000, "shr_c");
    send(OP_INC, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 4'b1001, "inc_wrap");
    send(OP_DEC, 16'h0000, 16'h8000, 1'b1, 1'b1, 16'h7FFF, 4'b0100, "dec_ovf");
    send(OP_SUB, 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 4'b1010, "sub_borrow");
    send(OP_SHL, 16'h0001, 16'h0000, 1'b1, 1'b1, 16'h0001, 4'b0000, "shl_zero_amt");
    send(4'd12,  16'h1234, 16'h5678, 1'b1, 1'b1, 16'h1234, 4'b0000, "reserved_pass");
    idle();
    @(negedge clk);
    check("result_hold", {16'd0, bus.result}, 32'h0000_1234);

    // ---- CCR restore on the same edge as a flag update ----------------------
    bus.ccr_restore = 1'b1;
    bus.ccr_in      = 4'b1010;
    send(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0002, 4'b1010, "add_restore");
    idle();
    @(negedge clk);

    // ---- multiply: 300*300 = 90000 -> low 16 bits 5F90 ---------------------
    send(OP_MUL, 16'd300, 16'd300, 1'b1, 1'b1, 16'h5F90, 4'b0000, "mul300");
    idle();
    busy_cyc = 0;
    ov_cyc   = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy && !bus.in_ready) busy_cyc++;
      if (bus.out_valid && ov_cyc == 0) ov_cyc = c;
      if (!bus.busy) break;
      if (c == 3 || c == 10) begin
        // Ignored while the multiplier is busy.
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.dst      = 16'h1111;
        bus.src      = 16'h2222;
        bus.flag_we  = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("mul_busy_cycles", busy_cyc, 17);
    check("mul_out_valid_cycle", ov_cyc, 17);

    // ---- multiply aborted by flush at cycle 5 -------------------------------
    send(OP_MUL, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 4'b0000, "");
    idle();
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_busy",     {31'd0, bus.busy},     32'd0);
    check("flush_ccr",      {28'd0, bus.ccr},      32'd0);
    check("flush_result",   {16'd0, bus.result},   32'h0000_5F90);
    repeat (20) @(negedge clk);

    // ---- flush with in_valid and ccr_restore in the same cycle --------------
    bus.flush       = 1'b1;
    bus.ccr_restore = 1'b1;
    bus.ccr_in      = 4'b0101;
    send(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0000, 4'b0000, "");
    idle();
    check("flush_restore_ccr", {28'd0, bus.ccr}, 32'd5);
    repeat (3) @(negedge clk);

    // ---- asynchronous reset in the middle of a multiply ---------------------
    send(OP_MUL, 16'd300, 16'd300, 1'b1, 1'b0, 16'h0000, 4'b0000, "");
    idle();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_result",    {16'd0, bus.result},    32'd0);
    check("arst_ccr",       {28'd0, bus.ccr},       32'd0);
    check("arst_busy",      {31'd0, bus.busy},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (25) @(negedge clk);

    // ---- shift by a full width ---------------------------------------------
    send(OP_SHL, 16'h8001, 16'd16, 1'b1, 1'b1, 16'h0000, 4'b1001, "shl_full");
    idle();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
